// File: rtl/axi_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_mailbox_slave
// Brief    : Single-beat AXI3 register slave providing a host<->fabric mailbox
//            (TX FIFO, RX FIFO, status, control, W1C interrupt status) and an
//            active-low registered interrupt line.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mailbox_slave #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          sysclk,
  input  logic          sysrstn,
  output logic          int_b,
  input  logic [31:0]   axis_awaddr,
  input  logic          axis_awvalid,
  output logic          axis_awready,
  input  logic [DW-1:0] axis_wdata,
  input  logic          axis_wvalid,
  output logic          axis_wready,
  output logic [1:0]    axis_bresp,
  output logic          axis_bvalid,
  input  logic          axis_bready,
  input  logic [31:0]   axis_araddr,
  input  logic          axis_arvalid,
  output logic          axis_arready,
  output logic [DW-1:0] axis_rdata,
  output logic [1:0]    axis_rresp,
  output logic          axis_rlast,
  output logic          axis_rvalid,
  input  logic          axis_rready,
  output logic [DW-1:0] tx_m_data,
  output logic          tx_m_valid,
  input  logic          tx_m_ready,
  input  logic [DW-1:0] rx_s_data,
  input  logic          rx_s_valid,
  output logic          rx_s_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [1:0]    RESP_DECERR = 2'b11;
  localparam logic [5:0]    A_TXDATA    = 6'h00;
  localparam logic [5:0]    A_RXDATA    = 6'h01;
  localparam logic [5:0]    A_STATUS    = 6'h02;
  localparam logic [5:0]    A_CTRL      = 6'h03;
  localparam logic [5:0]    A_IRQ       = 6'h04;

  typedef enum logic [1:0] {W_IDLE, W_WDATA, W_WADDR, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t          wstate_q;
  rstate_t          rstate_q;
  logic [5:0]       awaddr_q;
  logic [DW-1:0]    wdata_q, rdata_q;
  logic             awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [DW-1:0]    tx_mem [DEPTH];
  logic [DW-1:0]    rx_mem [DEPTH];
  logic [AW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]    tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic             rx_s_ready_q, rx_s_ready_d;
  logic [2:0]       irq_en_q, irq_en_d, irq_stat_q, irq_stat_d, irq_set;
  logic [7:0]       rx_thresh_q, rx_thresh_d, thresh_eff;
  logic             int_b_q, int_b_d;
  logic             wr_fire, rd_fire, flush;
  logic [5:0]       wr_idx, rd_idx;
  logic [DW-1:0]    wr_data, rd_data;
  logic [1:0]       wr_resp, rd_resp;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{axis_awaddr[31:8], axis_awaddr[1:0],
                              axis_araddr[31:8], axis_araddr[1:0]};

  assign tx_full  = (tx_count_q == FULL_CNT);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == FULL_CNT);
  assign rx_empty = (rx_count_q == '0);

  // Write-side decode: a write commits on the edge that completes AW and W.
  always_comb begin
    wr_fire = 1'b0;
    case (wstate_q)
      W_IDLE:  wr_fire = axis_awvalid && axis_wvalid;
      W_WDATA: wr_fire = axis_wvalid;
      W_WADDR: wr_fire = axis_awvalid;
      default: wr_fire = 1'b0;
    endcase
    wr_idx  = (wstate_q == W_WDATA) ? awaddr_q : axis_awaddr[7:2];
    wr_data = (wstate_q == W_WADDR) ? wdata_q : axis_wdata;
    case (wr_idx)
      A_TXDATA:      wr_resp = tx_full ? RESP_SLVERR : RESP_OKAY;
      A_CTRL, A_IRQ: wr_resp = RESP_OKAY;
      default:       wr_resp = RESP_DECERR;
    endcase
  end

  // Read-side decode: data and response captured at AR acceptance.
  always_comb begin
    rd_fire = (rstate_q == R_IDLE) && axis_arvalid;
    rd_idx  = axis_araddr[7:2];
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      A_TXDATA: rd_data = '0;
      A_RXDATA: begin
        if (rx_empty) rd_resp = RESP_SLVERR;
        else          rd_data = rx_mem[rx_rd_ptr_q];
      end
      A_STATUS: rd_data = {8'd0, 8'(rx_count_q), 8'(tx_count_q), 4'd0,
                           rx_full, rx_empty, tx_full, tx_empty};
      A_CTRL:   rd_data = {16'd0, rx_thresh_q, 5'd0, irq_en_q};
      A_IRQ:    rd_data = {29'd0, irq_stat_q};
      default:  rd_resp = RESP_DECERR;
    endcase
  end

  // FIFO pointers and counts; flush overrides any concurrent push or pop.
  always_comb begin
    tx_push     = wr_fire && (wr_idx == A_TXDATA) && !tx_full;
    tx_pop      = !tx_empty && tx_m_ready;
    rx_push     = rx_s_valid && rx_s_ready_q;
    rx_pop      = rd_fire && (rd_idx == A_RXDATA) && !rx_empty;
    flush       = wr_fire && (wr_idx == A_CTRL) && wr_data[31];
    tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_pop);
    tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
    rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_pop);
    rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    if (flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end
    rx_s_ready_d = (rx_count_d != FULL_CNT);
  end

  // Control and sticky interrupt status; a set beats a same-cycle W1C.
  always_comb begin
    irq_en_d    = irq_en_q;
    rx_thresh_d = rx_thresh_q;
    if (wr_fire && (wr_idx == A_CTRL)) begin
      irq_en_d    = wr_data[2:0];
      rx_thresh_d = wr_data[15:8];
    end
    thresh_eff = (rx_thresh_q == 8'd0) ? 8'd1 : rx_thresh_q;
    irq_set[0] = (8'(rx_count_q) >= thresh_eff);
    irq_set[1] = (tx_count_q == CW'(1)) && (tx_count_d == '0);
    irq_set[2] = wr_fire && (wr_idx == A_TXDATA) && tx_full;
    irq_stat_d = irq_stat_q;
    if (wr_fire && (wr_idx == A_IRQ)) irq_stat_d = irq_stat_q & ~wr_data[2:0];
    irq_stat_d = irq_stat_d | irq_set;
    int_b_d    = ~|(irq_stat_q & irq_en_q);
  end

  // Datapath and interrupt state registers.
  always_ff @(posedge sysclk) begin
    if (!sysrstn) begin
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      rx_s_ready_q <= 1'b0;
      irq_en_q     <= 3'd0;
      rx_thresh_q  <= 8'd1;
      irq_stat_q   <= 3'd0;
      int_b_q      <= 1'b1;
    end else begin
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
      rx_s_ready_q <= rx_s_ready_d;
      irq_en_q     <= irq_en_d;
      rx_thresh_q  <= rx_thresh_d;
      irq_stat_q   <= irq_stat_d;
      int_b_q      <= int_b_d;
    end
  end

  // FIFO storage, written only on accepted pushes.
  always_ff @(posedge sysclk) begin
    if (sysrstn && tx_push) tx_mem[tx_wr_ptr_q] <= wr_data;
    if (sysrstn && rx_push) rx_mem[rx_wr_ptr_q] <= rx_s_data;
  end

  // Write channel FSM: collects AW and W in either order, then holds B.
  always_ff @(posedge sysclk) begin
    if (!sysrstn) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= 6'd0;
      wdata_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_fire) begin
      wstate_q  <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_resp;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (axis_awvalid) begin
            wstate_q  <= W_WDATA;
            awaddr_q  <= axis_awaddr[7:2];
            awready_q <= 1'b0;
          end else if (axis_wvalid) begin
            wstate_q <= W_WADDR;
            wdata_q  <= axis_wdata;
            wready_q <= 1'b0;
          end
        end
        W_RESP: begin
          if (axis_bready) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  // Read channel FSM: one-cycle latency, R held until rready.
  always_ff @(posedge sysclk) begin
    if (!sysrstn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (rd_fire) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
          end
        end
        default: begin
          if (axis_rready) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  assign axis_awready = awready_q;
  assign axis_wready  = wready_q;
  assign axis_bvalid  = bvalid_q;
  assign axis_bresp   = bresp_q;
  assign axis_arready = arready_q;
  assign axis_rvalid  = rvalid_q;
  assign axis_rlast   = rvalid_q;
  assign axis_rdata   = rdata_q;
  assign axis_rresp   = rresp_q;
  assign tx_m_valid   = !tx_empty;
  assign tx_m_data    = tx_mem[tx_rd_ptr_q];
  assign rx_s_ready   = rx_s_ready_q;
  assign int_b        = int_b_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mailbox_slave
// Brief    : Self-checking bench: register-map vector table, directed corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mailbox_slave;
  localparam int DEPTH = 16;

  logic        sysclk = 1'b0, sysrstn = 1'b0;
  logic        int_b;
  logic [31:0] axis_awaddr = '0, axis_wdata = '0, axis_araddr = '0;
  logic        axis_awvalid = 1'b0, axis_wvalid = 1'b0, axis_bready = 1'b0;
  logic        axis_arvalid = 1'b0, axis_rready = 1'b0;
  logic        axis_awready, axis_wready, axis_bvalid, axis_arready;
  logic        axis_rlast, axis_rvalid;
  logic [1:0]  axis_bresp, axis_rresp;
  logic [31:0] axis_rdata, tx_m_data;
  logic        tx_m_valid, tx_m_ready = 1'b0;
  logic [31:0] rx_s_data = '0;
  logic        rx_s_valid = 1'b0, rx_s_ready;

  int n_checks = 0, n_errors = 0;

  // Reference model state
  logic [31:0] mtx[$], mrx[$];
  logic [2:0]  m_stat, m_en;
  logic [7:0]  m_th;

  axi_mailbox_slave #(.DEPTH(DEPTH), .DW(32)) dut (
    .sysclk(sysclk), .sysrstn(sysrstn), .int_b(int_b),
    .axis_awaddr(axis_awaddr), .axis_awvalid(axis_awvalid), .axis_awready(axis_awready),
    .axis_wdata(axis_wdata), .axis_wvalid(axis_wvalid), .axis_wready(axis_wready),
    .axis_bresp(axis_bresp), .axis_bvalid(axis_bvalid), .axis_bready(axis_bready),
    .axis_araddr(axis_araddr), .axis_arvalid(axis_arvalid), .axis_arready(axis_arready),
    .axis_rdata(axis_rdata), .axis_rresp(axis_rresp), .axis_rlast(axis_rlast),
    .axis_rvalid(axis_rvalid), .axis_rready(axis_rready),
    .tx_m_data(tx_m_data), .tx_m_valid(tx_m_valid), .tx_m_ready(tx_m_ready),
    .rx_s_data(rx_s_data), .rx_s_valid(rx_s_valid), .rx_s_ready(rx_s_ready)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic do_reset();
    sysrstn = 1'b0;
    axis_awvalid = 1'b0; axis_wvalid = 1'b0; axis_bready = 1'b0;
    axis_arvalid = 1'b0; axis_rready = 1'b0;
    tx_m_ready = 1'b0; rx_s_valid = 1'b0;
    tick(2);
    sysrstn = 1'b1;
    tick(1);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int guard;
    aw_done = 0; w_done = 0; guard = 0;
    axis_awaddr = a; axis_wdata = d; axis_awvalid = 1'b1; axis_wvalid = 1'b1;
    while (!(aw_done && w_done)) begin
      aw_hs = axis_awvalid && axis_awready;
      w_hs  = axis_wvalid && axis_wready;
      tick();
      if (aw_hs) begin aw_done = 1; axis_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  axis_wvalid = 1'b0; end
      guard++;
      if (guard > 50) begin timeout("write addr/data"); break; end
    end
    axis_awvalid = 1'b0; axis_wvalid = 1'b0;
    guard = 0;
    while (!axis_bvalid && guard < 50) begin tick(); guard++; end
    if (!axis_bvalid) begin
      timeout("write bvalid");
      resp = 2'b01;
      return;
    end
    resp = axis_bresp;
    axis_bready = 1'b1;
    tick();
    axis_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs;
    int guard;
    guard = 0;
    axis_araddr = a; axis_arvalid = 1'b1;
    do begin
      hs = axis_arready;
      tick();
      guard++;
    end while (!hs && guard < 50);
    axis_arvalid = 1'b0;
    if (!hs) begin timeout("read addr"); d = '0; resp = 2'b01; return; end
    guard = 0;
    while (!axis_rvalid && guard < 50) begin tick(); guard++; end
    if (!axis_rvalid) begin timeout("read rvalid"); d = '0; resp = 2'b01; return; end
    check("rlast_eq_rvalid", {31'd0, axis_rlast}, 32'd1);
    d = axis_rdata;
    resp = axis_rresp;
    axis_rready = 1'b1;
    tick();
    axis_rready = 1'b0;
  endtask

  task automatic fabric_push(input logic [31:0] d);
    bit hs;
    int guard;
    guard = 0;
    rx_s_data = d; rx_s_valid = 1'b1;
    do begin
      hs = rx_s_ready;
      tick();
      guard++;
    end while (!hs && guard < 50);
    rx_s_valid = 1'b0;
    if (!hs) timeout("fabric push");
  endtask

  function automatic logic [31:0] m_status();
    int r, t;
    r = mrx.size();
    t = mtx.size();
    return {8'd0, 8'(r), 8'(t), 4'd0, r == DEPTH, r == 0, t == DEPTH, t == 0};
  endfunction

  task automatic model_level();
    int th;
    th = (m_th == 8'd0) ? 1 : int'(m_th);
    if (mrx.size() >= th) m_stat[0] = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, wd;
    logic [31:0] ctrl_a, ctrl_b;

    vecs[0]  = '{0, 32'h08, 32'h0,         2'b00, 32'h0000_0005};
    vecs[1]  = '{1, 32'h0C, 32'h0000_0104, 2'b00, 32'h0};
    vecs[2]  = '{0, 32'h0C, 32'h0,         2'b00, 32'h0000_0104};
    vecs[3]  = '{1, 32'h08, 32'h1234_5678, 2'b11, 32'h0};
    vecs[4]  = '{1, 32'h04, 32'h1234_5678, 2'b11, 32'h0};
    vecs[5]  = '{1, 32'h3C, 32'hFFFF_FFFF, 2'b11, 32'h0};
    vecs[6]  = '{0, 32'h20, 32'h0,         2'b11, 32'h0};
    vecs[7]  = '{0, 32'h04, 32'h0,         2'b10, 32'h0};
    vecs[8]  = '{1, 32'h0C, 32'h8000_0203, 2'b00, 32'h0};
    vecs[9]  = '{0, 32'h0C, 32'h0,         2'b00, 32'h0000_0203};
    vecs[10] = '{0, 32'h10, 32'h0,         2'b00, 32'h0};
    vecs[11] = '{0, 32'h0B, 32'h0,         2'b00, 32'h0000_0005};
    vecs[12] = '{0, 32'h108, 32'h0,        2'b00, 32'h0000_0005};
    vecs[13] = '{0, 32'h00, 32'h0,         2'b00, 32'h0};
    vecs[14] = '{1, 32'h0C, 32'h7FFF_01F9, 2'b00, 32'h0};
    vecs[15] = '{0, 32'h0C, 32'h0,         2'b00, 32'h0000_0101};

    // Reset state
    tick(2);
    check("rst_int_b", {31'd0, int_b}, 32'd1);
    check("rst_rx_s_ready", {31'd0, rx_s_ready}, 32'd0);
    check("rst_tx_m_valid", {31'd0, tx_m_valid}, 32'd0);
    check("rst_readies", {29'd0, axis_awready, axis_wready, axis_arready}, 32'd7);
    check("rst_valids", {29'd0, axis_bvalid, axis_rvalid, axis_rlast}, 32'd0);
    check("rst_resp_data", axis_rdata | {28'd0, axis_bresp, axis_rresp}, 32'd0);
    sysrstn = 1'b1;
    tick(1);
    check("rx_s_ready_after_rst", {31'd0, rx_s_ready}, 32'd1);

    // Register-map vector table
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, resp);
        check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      end
    end

    // TX overflow, interrupt enable, W1C, then drain with tx-empty interrupt
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      axi_write(32'h00, 32'hA5A5_0000 + i, resp);
      check($sformatf("tx_fill%0d_bresp", i), {30'd0, resp}, 32'd0);
    end
    axi_write(32'h00, 32'hA5A5_0011, resp);
    check("tx_ovf_bresp", {30'd0, resp}, 32'd2);
    axi_read(32'h10, rd, resp);
    check("tx_ovf_irq", rd, 32'h4);
    axi_read(32'h08, rd, resp);
    check("tx_full_status", rd, 32'h0000_1006);
    axi_write(32'h0C, 32'h0000_0104, resp);
    tick(2);
    check("tx_ovf_int_b", {31'd0, int_b}, 32'd0);
    axi_write(32'h10, 32'h4, resp);
    check("w1c_int_b", {31'd0, int_b}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check("tx_drain_valid", {31'd0, tx_m_valid}, 32'd1);
      check($sformatf("tx_drain%0d_data", i), tx_m_data, 32'hA5A5_0000 + i);
      tx_m_ready = 1'b1;
      tick();
      tx_m_ready = 1'b0;
    end
    check("tx_empty_valid", {31'd0, tx_m_valid}, 32'd0);
    tick(1);
    axi_read(32'h10, rd, resp);
    check("tx_empty_irq", rd, 32'h2);

    // AW three cycles ahead of W, response held under bready=0
    do_reset();
    axis_awaddr = 32'h0C; axis_awvalid = 1'b1; axis_wdata = 32'h0000_0305;
    tick();
    axis_awvalid = 1'b0;
    check("awfirst_awready", {31'd0, axis_awready}, 32'd0);
    tick(2);
    check("awfirst_no_early_b", {31'd0, axis_bvalid}, 32'd0);
    axis_wvalid = 1'b1;
    tick();
    axis_wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("awfirst_bhold%0d", k), {29'd0, axis_bvalid, axis_awready, axis_wready}, 32'd4);
      if (k < 3) tick();
    end
    check("awfirst_bresp", {30'd0, axis_bresp}, 32'd0);
    axis_bready = 1'b1;
    tick();
    axis_bready = 1'b0;
    check("awfirst_b_done", {30'd0, axis_bvalid, axis_awready}, 32'd1);
    axi_read(32'h0C, ctrl_a, resp);
    check("awfirst_ctrl", ctrl_a, 32'h0000_0305);

    // Same register write with W ahead of AW
    do_reset();
    axis_wdata = 32'h0000_0305; axis_wvalid = 1'b1;
    tick();
    axis_wvalid = 1'b0;
    check("wfirst_wready", {31'd0, axis_wready}, 32'd0);
    tick(2);
    check("wfirst_no_early_b", {31'd0, axis_bvalid}, 32'd0);
    axis_awaddr = 32'h0C; axis_awvalid = 1'b1;
    tick();
    axis_awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wfirst_bhold%0d", k), {31'd0, axis_bvalid}, 32'd1);
      if (k < 3) tick();
    end
    axis_bready = 1'b1;
    tick();
    axis_bready = 1'b0;
    axi_read(32'h0C, ctrl_b, resp);
    check("wfirst_ctrl_same", ctrl_b, 32'h0000_0305);

    // RX threshold interrupt and RXDATA pops
    do_reset();
    axi_write(32'h0C, 32'h0000_0201, resp);
    fabric_push(32'h11);
    fabric_push(32'h22);
    tick(3);
    axi_read(32'h10, rd, resp);
    check("rx_thresh_irq", rd & 32'h1, 32'h1);
    check("rx_thresh_int_b", {31'd0, int_b}, 32'd0);
    axi_read(32'h04, rd, resp);
    check("rx_pop1", {rd[29:0], resp}, {30'h11, 2'b00});
    axi_read(32'h04, rd, resp);
    check("rx_pop2", {rd[29:0], resp}, {30'h22, 2'b00});
    axi_read(32'h04, rd, resp);
    check("rx_pop_empty", {rd[29:0], resp}, {30'h0, 2'b10});

    // Concurrent fabric push and AXI pop at a full RX FIFO
    do_reset();
    for (int i = 0; i < 16; i++) fabric_push(32'h100 + i);
    check("rx_full_ready", {31'd0, rx_s_ready}, 32'd0);
    axi_read(32'h08, rd, resp);
    check("rx_full_status", rd, 32'h0010_0009);
    rx_s_data = 32'hDEAD_0000; rx_s_valid = 1'b1;
    axis_araddr = 32'h04; axis_arvalid = 1'b1;
    check("rx_full_concurrent_ready", {31'd0, rx_s_ready}, 32'd0);
    tick();
    axis_arvalid = 1'b0;
    check("rx_pop_at_full_data", axis_rdata, 32'h100);
    check("rx_ready_after_pop", {30'd0, axis_rvalid, rx_s_ready}, 32'd3);
    axis_rready = 1'b1;
    tick();
    axis_rready = 1'b0; rx_s_valid = 1'b0;
    axi_read(32'h08, rd, resp);
    check("rx_refill_status", rd, 32'h0010_0009);
    for (int i = 1; i <= 16; i++) begin
      axi_read(32'h04, rd, resp);
      check($sformatf("rx_order%0d", i), rd, (i == 16) ? 32'hDEAD_0000 : 32'h100 + i);
    end

    // Reset while read data is pending
    do_reset();
    fabric_push(32'h55);
    axi_write(32'h00, 32'h66, resp);
    axis_araddr = 32'h08; axis_arvalid = 1'b1;
    tick();
    axis_arvalid = 1'b0;
    tick();
    check("rdata_pending", {31'd0, axis_rvalid}, 32'd1);
    sysrstn = 1'b0;
    tick();
    check("rst_mid_read", {29'd0, axis_rvalid, axis_rlast, tx_m_valid}, 32'd0);
    check("rst_mid_int_b", {31'd0, int_b}, 32'd1);
    sysrstn = 1'b1;
    tick();
    axi_read(32'h08, rd, resp);
    check("post_rst_status", {rd[29:0], resp}, {30'h5, 2'b00});

    // Randomized traffic against the queue model
    do_reset();
    mtx.delete(); mrx.delete();
    m_stat = 3'd0; m_en = 3'd0; m_th = 8'd1;
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 15);
      case (op)
        0, 1, 2: begin
          wd = $urandom;
          axi_write(32'h00, wd, resp);
          if (mtx.size() == DEPTH) begin
            check("rnd_tx_bresp", {30'd0, resp}, 32'd2);
            m_stat[2] = 1'b1;
          end else begin
            check("rnd_tx_bresp", {30'd0, resp}, 32'd0);
            mtx.push_back(wd);
          end
        end
        3, 4: begin
          axi_read(32'h04, rd, resp);
          if (mrx.size() == 0) begin
            check("rnd_rx_empty", {rd[29:0], resp}, {30'd0, 2'b10});
          end else begin
            check("rnd_rx_data", rd, mrx[0]);
            check("rnd_rx_rresp", {30'd0, resp}, 32'd0);
            void'(mrx.pop_front());
          end
        end
        5: begin
          axi_read(32'h08, rd, resp);
          check("rnd_status", rd, m_status());
        end
        6, 7, 8: begin
          wd = $urandom;
          rx_s_data = wd; rx_s_valid = 1'b1;
          check("rnd_rx_s_ready", {31'd0, rx_s_ready}, {31'd0, mrx.size() < DEPTH});
          tick();
          rx_s_valid = 1'b0;
          if (mrx.size() < DEPTH) mrx.push_back(wd);
        end
        9, 10: begin
          check("rnd_tx_m_valid", {31'd0, tx_m_valid}, {31'd0, mtx.size() != 0});
          if (mtx.size() != 0) check("rnd_tx_m_data", tx_m_data, mtx[0]);
          tx_m_ready = 1'b1;
          tick();
          tx_m_ready = 1'b0;
          if (mtx.size() != 0) begin
            void'(mtx.pop_front());
            if (mtx.size() == 0) m_stat[1] = 1'b1;
          end
        end
        11: begin
          logic fl;
          logic [2:0] en;
          logic [7:0] th;
          fl = ($urandom_range(0, 7) == 0);
          en = 3'($urandom_range(0, 7));
          th = 8'($urandom_range(0, 5));
          wd = {fl, 15'($urandom), th, 5'($urandom), en};
          axi_write(32'h0C, wd, resp);
          check("rnd_ctrl_bresp", {30'd0, resp}, 32'd0);
          if (fl) begin
            if (mtx.size() == 1) m_stat[1] = 1'b1;
            mtx.delete();
            mrx.delete();
          end
          m_en = en;
          m_th = th;
        end
        12: begin
          axi_read(32'h10, rd, resp);
          check("rnd_irq_stat", rd, {29'd0, m_stat});
        end
        13: begin
          wd = $urandom;
          axi_write(32'h10, wd, resp);
          check("rnd_w1c_bresp", {30'd0, resp}, 32'd0);
          m_stat = m_stat & ~wd[2:0];
          model_level();
        end
        14: begin
          axi_read(32'h0C, rd, resp);
          check("rnd_ctrl", rd, {16'd0, m_th, 5'd0, m_en});
        end
        default: tick();
      endcase
      tick(2);
      model_level();
      check("rnd_int_b", {31'd0, int_b}, {31'd0, ~|(m_stat & m_en)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_mailbox_slave.md
Name: axi_mailbox_slave

Overview:
Memory-mapped AXI3 single-beat slave for the 32-bit AXI master port of axi_bus_m32_bridge, decoded on address bits [7:0].
- Provides a bidirectional mailbox between the bridge-side host and fabric user logic:
  - host→fabric TX FIFO;
  - fabric→host RX FIFO;
  - status, control and W1C interrupt registers.
- Drives the active-low FPGA_INT_B line back to the bridge (ext0_int).

Parameters:
DEPTH, 16, entries per FIFO (power of two, 2..128)
DW, 32, data width (fixed to AXI data width)

Ports:
sysclk  in  1  clock; all logic on rising edge
sysrstn  in  1  synchronous active-low reset
int_b  out  1  interrupt, active low, registered
axis_awaddr  in  32  write address; only [7:2] decoded
axis_awvalid  in  1  write address valid
axis_awready  out  1  write address ready
axis_wdata  in  32  write data
axis_wvalid  in  1  write data valid
axis_wready  out  1  write data ready
axis_bresp  out  2  write response
axis_bvalid  out  1  write response valid
axis_bready  in  1  write response ready
axis_araddr  in  32  read address; only [7:2] decoded
axis_arvalid  in  1  read address valid
axis_arready  out  1  read address ready
axis_rdata  out  32  read data
axis_rresp  out  2  read response
axis_rlast  out  1  last beat; equals axis_rvalid
axis_rvalid  out  1  read data valid
axis_rready  in  1  read data ready
tx_m_data  out  32  TX FIFO head (first-word-fall-through)
tx_m_valid  out  1  TX FIFO not empty
tx_m_ready  in  1  fabric pops TX head when valid&ready
rx_s_data  in  32  fabric data into RX FIFO
rx_s_valid  in  1  fabric push request
rx_s_ready  out  1  RX FIFO not full (registered)

Behaviour:
- Reset (sysrstn=0 at edge):
  - FIFOs empty, counts 0; IRQ_EN=0; IRQ_STAT=0; RX_THRESH=1.
  - awready=wready=arready=1; bvalid=rvalid=rlast=0; bresp=rresp=0; rdata=0.
  - int_b=1, tx_m_valid=0, rx_s_ready=0 during reset, 1 the cycle after.
  - Reset mid-transaction abandons it; no response is issued.
- Only single-beat transfers: len/size/burst/id/strb/wlast are not ports; wstrb is treated as all-ones.
- Register map:
  - 0x00 TXDATA WO: push wdata into TX FIFO.
  - 0x04 RXDATA RO: pop RX FIFO head.
  - 0x08 STATUS RO: [23:16] rx_count, [15:8] tx_count, [3] rx_full, [2] rx_empty, [1] tx_full, [0] tx_empty.
  - 0x0C CTRL RW: [2:0] IRQ_EN, [15:8] RX_THRESH; [31] flush, write-only, self-clearing; reads 0.
  - 0x10 IRQ_STAT W1C, bits [2:0]. Reads of write-only or unused bits return 0.
- Write FSM:
  - W_IDLE: awready=wready=1.
    - AW and W in the same cycle → W_RESP.
    - AW only → latch address, W_WDATA (awready=0).
    - W only → latch data, W_WADDR (wready=0).
  - W_WDATA/W_WADDR: wait for the missing half → W_RESP.
  - The register update happens on the cycle of entry to W_RESP.
  - W_RESP: bvalid=1, awready=wready=0; hold bresp until bvalid&bready → W_IDLE.
  - bresp: OKAY=00; TXDATA while tx_full → SLVERR=10, data dropped, IRQ_STAT[2] set; unmapped or RXDATA/STATUS address → DECERR=11, no effect.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, register rdata/rresp, → R_DATA next cycle (latency 1).
  - R_DATA: rvalid=rlast=1, arready=0; hold until rready → R_IDLE.
  - RXDATA pop occurs at AR acceptance.
  - RXDATA while rx_empty → rdata=0, SLVERR, no pop.
  - Unmapped → rdata=0, DECERR.
- Read and write FSMs are independent and may complete in the same cycle.
  - A read of IRQ_STAT concurrent with a W1C returns the pre-clear value.
- FIFOs:
  - count width log2(DEPTH)+1, zero-extended into STATUS.
  - Simultaneous push and pop leaves count unchanged.
  - rx_s_ready is registered from the next count, so a push is never accepted when full.
  - Flush empties both FIFOs in the W_RESP-entry cycle; a concurrent fabric push/pop that cycle is discarded.
- Interrupts (sticky; a set in the same cycle as a W1C wins):
  - [0] set whenever rx_count >= RX_THRESH (level-sampled each cycle; RX_THRESH=0 treated as 1).
  - [1] set on tx_count transition 1→0.
  - [2] set on TX overflow write.
  - int_b next = ~|(IRQ_STAT & IRQ_EN).

Test Plan:
- Reset, then read 0x08 → rdata=0x0000_0005, OKAY; int_b=1; rx_s_ready=1 one cycle after reset release.
- Write 0x00 with 0xA5A5_0001..0xA5A5_0010 (DEPTH=16): 16 OKAY; 17th → SLVERR, IRQ_STAT=0x4; with CTRL=0x0000_0104, int_b=0; W1C 0x4 → int_b=1 after 2 cycles.
- AW presented 3 cycles before W → single bvalid pulse held 4 cycles under bready=0. Repeat with W first; register result is identical.
- Fabric pushes 0x11,0x22 with CTRL RX_THRESH=2, IRQ_EN=1 → IRQ_STAT[0]=1 and int_b=0. Reads of 0x04 → 0x11, 0x22 (OKAY), then 0 with SLVERR.
- Simultaneous fabric push and AXI RXDATA pop at rx_count=16 → rx_s_ready=0 that cycle; count becomes 15, then 16 after the push is accepted next cycle; no data loss, order preserved.
- Reset asserted while in R_DATA with rready=0 → rvalid=0 next cycle; FIFOs empty; following transaction completes normally.
